// File: rtl/timing_pkg.sv
// timing_pkg: shared constants and encodings for the trip-timing blocks
package timing_pkg;
  localparam int ACCUM_W = 13;
  localparam int LONGPRESS_SEC = 2;
  localparam int IDLE_TIMEOUT_SEC = 5;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;
  localparam logic [1:0] DISP_HMS = 2'd0;
  localparam logic [1:0] DISP_SEC = 2'd1;
  localparam logic [1:0] DISP_MIN = 2'd2;
endpackage

// File: rtl/btn_press_classifier.sv
// btn_press_classifier: edge detect plus second-counted hold classifying short/long presses
module btn_press_classifier #(
  parameter int HOLD_SEC = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  input  logic sec_pulse,
  output logic rise,
  output logic short_press,
  output logic long_press
);
  localparam int HW = $clog2(HOLD_SEC + 1);
  localparam logic [HW-1:0] HMAX = HW'(HOLD_SEC);
  logic btn_q, done_q, done_d, fall, inc;
  logic [HW-1:0] hold_q, hold_d;
  // edges, saturating hold count and press classification
  always_comb begin
    rise = btn & ~btn_q;
    fall = ~btn & btn_q;
    inc = sec_pulse & btn & ~rise & (hold_q != HMAX);
    long_press = inc & (hold_q == HMAX - 1'b1);
    short_press = fall & ~done_q;
    hold_d = rise ? '0 : inc ? hold_q + 1'b1 : hold_q;
    done_d = fall ? 1'b0 : long_press ? 1'b1 : done_q;
  end
  // reset presets btn_q/done_q so a button held through reset yields neither a rise nor a short press on release
  always_ff @(posedge clock) begin
    if (reset) begin
      btn_q <= 1'b1;
      done_q <= 1'b1;
      hold_q <= '0;
    end else begin
      btn_q <= btn;
      done_q <= done_d;
      hold_q <= hold_d;
    end
  end
endmodule

// File: rtl/timing_ctrl.sv
// timing_ctrl: run/pause/clear controller gating the trip accumulators, display select and pause blink
module timing_ctrl
  import timing_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               start_btn,
  input  logic               mode_btn,
  input  logic               wheel_pulse,
  input  logic               sec_pulse,
  input  logic               half_sec_pulse,
  input  logic [ACCUM_W-1:0] min_accum,
  output logic               accum_en,
  output logic               accum_clr,
  output logic [1:0]         disp_sel,
  output logic               blink,
  output logic [1:0]         state
);
  localparam int IW = $clog2(IDLE_TIMEOUT_SEC + 1);
  localparam logic [IW-1:0] IMAX = IW'(IDLE_TIMEOUT_SEC);
  state_t state_q, state_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [1:0] disp_q, disp_d;
  logic auto_q, auto_d, blink_q, blink_d, sat, timeout;
  logic start_short, start_long, mode_rise;
  logic start_rise_unused, mode_short_unused, mode_long_unused;
  btn_press_classifier #(.HOLD_SEC(LONGPRESS_SEC)) u_start (
    .clock(clock), .reset(reset), .btn(start_btn), .sec_pulse(sec_pulse),
    .rise(start_rise_unused), .short_press(start_short), .long_press(start_long)
  );
  btn_press_classifier #(.HOLD_SEC(LONGPRESS_SEC)) u_mode (
    .clock(clock), .reset(reset), .btn(mode_btn), .sec_pulse(sec_pulse),
    .rise(mode_rise), .short_press(mode_short_unused), .long_press(mode_long_unused)
  );
  // idle seconds count only in RUN, wheel wins over a coincident second; zero outside RUN so entry starts clean
  always_comb begin
    sat = &min_accum;
    idle_d = (state_q != ST_RUN || wheel_pulse) ? '0 : (sec_pulse && idle_q != IMAX) ? idle_q + 1'b1 : idle_q;
    timeout = idle_d == IMAX;
    blink_d = (state_q == ST_PAUSE) ? blink_q ^ half_sec_pulse : 1'b1;
    disp_d = mode_rise ? (disp_q == DISP_MIN ? DISP_HMS : disp_q + 1'b1) : disp_q;
  end
  // next state with priority long press > saturation > short press > timeout/wheel
  always_comb begin
    state_d = state_q;
    auto_d = auto_q;
    case (state_q)
      ST_IDLE: if (start_short) state_d = ST_RUN;
      ST_RUN:
        if (start_long) state_d = ST_CLEAR;
        else if (sat || start_short) begin
          state_d = ST_PAUSE;
          auto_d = 1'b0;
        end else if (timeout) begin
          state_d = ST_PAUSE;
          auto_d = 1'b1;
        end
      ST_PAUSE:
        if (start_long) state_d = ST_CLEAR;
        else if (!sat && (start_short || (wheel_pulse && auto_q))) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
    if (state_d != ST_PAUSE) auto_d = 1'b0;
  end
  // state and housekeeping registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idle_q <= '0;
      auto_q <= 1'b0;
      blink_q <= 1'b1;
      disp_q <= DISP_HMS;
    end else begin
      state_q <= state_d;
      idle_q <= idle_d;
      auto_q <= auto_d;
      blink_q <= blink_d;
      disp_q <= disp_d;
    end
  end
  assign accum_en = state_q == ST_RUN;
  assign accum_clr = state_q == ST_CLEAR;
  assign disp_sel = disp_q;
  assign blink = blink_q | (state_q != ST_PAUSE);
  assign state = state_q;
endmodule
